// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU with a two-stage in-flight scoreboard and RAW-hazard stall.
// Optional macro ALU_ISSUE_FWD_EN forwards the S2 result to a new op instead of stalling on it.
module alu_issue_ctrl #(
    parameter int                 DATA_W = 8,
    parameter logic [DATA_W-1:0]  RST_A  = '0,
    parameter logic [DATA_W-1:0]  RST_B  = '0
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [7:0]        REQ_INSTR,
    input  logic [7:0]        REQ_IMM,
    input  logic              REQ_WB,
    input  logic              REQ_DST,
    input  logic              LD_EN,
    input  logic              LD_SEL,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic [DATA_W-1:0] ALU_IN_A,
    output logic [DATA_W-1:0] ALU_IN_B,
    output logic [7:0]        ALU_IMM,
    output logic [7:0]        ALU_INSTRUCT,
    input  logic [DATA_W-1:0] ALU_RESULT,
    output logic              RES_VALID,
    output logic [DATA_W-1:0] RES_DATA,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic              BUSY
);

    logic              s1_valid, s1_wb, s1_dst;
    logic              s2_valid, s2_wb, s2_dst;
    logic              s2_wb_a, s2_wb_b;
    logic              accept;
    logic [DATA_W-1:0] issue_a, issue_b;

    assign s2_wb_a = s2_valid & s2_wb & ~s2_dst;
    assign s2_wb_b = s2_valid & s2_wb &  s2_dst;

`ifdef ALU_ISSUE_FWD_EN
    // The S2 result is on ALU_RESULT this cycle, so only an S1 writeback still blocks issue.
    assign REQ_READY = RESETN & ~(s1_valid & s1_wb);
    assign issue_a   = s2_wb_a ? ALU_RESULT : REG_A;
    assign issue_b   = s2_wb_b ? ALU_RESULT : REG_B;
`else
    assign REQ_READY = RESETN & ~(s1_valid & s1_wb) & ~(s2_valid & s2_wb);
    assign issue_a   = REG_A;
    assign issue_b   = REG_B;
`endif

    assign accept = REQ_VALID & REQ_READY;
    assign BUSY   = s1_valid | s2_valid;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1_valid     <= 1'b0;
            s1_wb        <= 1'b0;
            s1_dst       <= 1'b0;
            s2_valid     <= 1'b0;
            s2_wb        <= 1'b0;
            s2_dst       <= 1'b0;
            ALU_IN_A     <= '0;
            ALU_IN_B     <= '0;
            ALU_IMM      <= '0;
            ALU_INSTRUCT <= '0;
            RES_VALID    <= 1'b0;
            RES_DATA     <= '0;
            REG_A        <= RST_A;
            REG_B        <= RST_B;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_wb        <= REQ_WB;
                s1_dst       <= REQ_DST;
                ALU_IN_A     <= issue_a;
                ALU_IN_B     <= issue_b;
                ALU_IMM      <= REQ_IMM;
                ALU_INSTRUCT <= REQ_INSTR;
            end

            s2_valid  <= s1_valid;
            s2_wb     <= s1_wb;
            s2_dst    <= s1_dst;

            RES_VALID <= s2_valid;
            if (s2_valid) begin
                RES_DATA <= ALU_RESULT;
            end

            // A host load at the same edge as a writeback to the same register takes priority.
            if (LD_EN && !LD_SEL) begin
                REG_A <= LD_DATA;
            end else if (s2_wb_a) begin
                REG_A <= ALU_RESULT;
            end

            if (LD_EN && LD_SEL) begin
                REG_B <= LD_DATA;
            end else if (s2_wb_b) begin
                REG_B <= ALU_RESULT;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a registered ALU stand-in, an op-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_alu_issue_ctrl;

    logic       CLK;
    logic       RESETN;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_INSTR;
    logic [7:0] REQ_IMM;
    logic       REQ_WB;
    logic       REQ_DST;
    logic       LD_EN;
    logic       LD_SEL;
    logic [7:0] LD_DATA;
    logic [7:0] ALU_IN_A;
    logic [7:0] ALU_IN_B;
    logic [7:0] ALU_IMM;
    logic [7:0] ALU_INSTRUCT;
    logic [7:0] ALU_RESULT;
    logic       RES_VALID;
    logic [7:0] RES_DATA;
    logic [7:0] REG_A;
    logic [7:0] REG_B;
    logic       BUSY;

    int checks;
    int errors;

    alu_issue_ctrl #(.DATA_W(8), .RST_A(8'h00), .RST_B(8'h00)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_INSTR(REQ_INSTR), .REQ_IMM(REQ_IMM), .REQ_WB(REQ_WB), .REQ_DST(REQ_DST),
        .LD_EN(LD_EN), .LD_SEL(LD_SEL), .LD_DATA(LD_DATA),
        .ALU_IN_A(ALU_IN_A), .ALU_IN_B(ALU_IN_B), .ALU_IMM(ALU_IMM), .ALU_INSTRUCT(ALU_INSTRUCT),
        .ALU_RESULT(ALU_RESULT),
        .RES_VALID(RES_VALID), .RES_DATA(RES_DATA),
        .REG_A(REG_A), .REG_B(REG_B), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in ALU: imm select 0xD picks IMM as the second operand.
    function automatic logic [7:0] alu_fn(input logic [7:0] instr, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm);
        logic [7:0] opb;
        opb = (instr[3:0] == 4'hD) ? imm : b;
        case (instr[7:4])
            4'h0:    return a + opb;
            4'h5:    return a + 8'd1;
            4'h9:    return {7'd0, a == opb};
            4'hA:    return {7'd0, a > opb};
            4'hB:    return {7'd0, a < opb};
            default: return a ^ opb;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (!RESETN) ALU_RESULT <= 8'h00;
        else         ALU_RESULT <= alu_fn(ALU_INSTRUCT, ALU_IN_A, ALU_IN_B, ALU_IMM);
    end

    typedef struct {
        int         left;
        bit         wb;
        bit         dst;
        logic [7:0] res;
    } flight_t;

    flight_t    flight[$];
    bit         model_valid = 1'b0;
    logic [7:0] m_a, m_b, m_res_data, m_alu_a, m_alu_b, m_alu_imm, m_alu_instr;
    bit         m_res_valid;
    logic [7:0] n_a, n_b, op_a, op_b;
    bit         can_issue, have_done;
    flight_t    done_op, fresh;

    // An op may issue only when no writeback it would have to wait on is still in flight.
    function automatic bit model_ready();
        bit r;
        r = (RESETN === 1'b1);
        foreach (flight[i]) begin
            if (flight[i].wb && flight[i].left == 2) r = 1'b0;
`ifndef ALU_ISSUE_FWD_EN
            if (flight[i].wb && flight[i].left == 1) r = 1'b0;
`endif
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (RESETN === 1'b0) begin
            flight.delete();
            m_a = 8'h00; m_b = 8'h00;
            m_res_valid = 1'b0; m_res_data = 8'h00;
            m_alu_a = 8'h00; m_alu_b = 8'h00; m_alu_imm = 8'h00; m_alu_instr = 8'h00;
            model_valid = 1'b1;
        end else if (model_valid) begin
            can_issue = model_ready();
            n_a = m_a;
            n_b = m_b;
            have_done = 1'b0;
            m_res_valid = 1'b0;
            foreach (flight[i]) begin
                if (flight[i].left == 1) begin
                    have_done = 1'b1;
                    done_op = flight[i];
                end
            end
            if (have_done) begin
                m_res_valid = 1'b1;
                m_res_data = done_op.res;
                if (done_op.wb) begin
                    if (done_op.dst) n_b = done_op.res;
                    else             n_a = done_op.res;
                end
            end
            if (LD_EN) begin
                if (LD_SEL) n_b = LD_DATA;
                else        n_a = LD_DATA;
            end
            for (int i = flight.size() - 1; i >= 0; i--) begin
                flight[i].left = flight[i].left - 1;
                if (flight[i].left == 0) flight.delete(i);
            end
            if (REQ_VALID && can_issue) begin
                op_a = m_a;
                op_b = m_b;
`ifdef ALU_ISSUE_FWD_EN
                if (have_done && done_op.wb) begin
                    if (done_op.dst) op_b = done_op.res;
                    else             op_a = done_op.res;
                end
`endif
                m_alu_a = op_a; m_alu_b = op_b; m_alu_imm = REQ_IMM; m_alu_instr = REQ_INSTR;
                fresh.left = 2;
                fresh.wb   = REQ_WB;
                fresh.dst  = REQ_DST;
                fresh.res  = alu_fn(REQ_INSTR, op_a, op_b, REQ_IMM);
                flight.push_back(fresh);
            end
            m_a = n_a;
            m_b = n_b;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        checkOutput("REQ_READY", {7'd0, REQ_READY}, {7'd0, model_ready()});
        checkOutput("BUSY", {7'd0, BUSY}, {7'd0, flight.size() != 0});
        checkOutput("RES_VALID", {7'd0, RES_VALID}, {7'd0, m_res_valid});
        checkOutput("RES_DATA", RES_DATA, m_res_data);
        checkOutput("REG_A", REG_A, m_a);
        checkOutput("REG_B", REG_B, m_b);
        checkOutput("ALU_IN_A", ALU_IN_A, m_alu_a);
        checkOutput("ALU_IN_B", ALU_IN_B, m_alu_b);
        checkOutput("ALU_IMM", ALU_IMM, m_alu_imm);
        checkOutput("ALU_INSTRUCT", ALU_INSTRUCT, m_alu_instr);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input logic [7:0] instr, input logic [7:0] imm,
                                 input bit wb, input bit dst,
                                 input bit ld, input bit ld_sel, input logic [7:0] ld_data);
        REQ_VALID = valid;
        REQ_INSTR = instr;
        REQ_IMM   = imm;
        REQ_WB    = wb;
        REQ_DST   = dst;
        LD_EN     = ld;
        LD_SEL    = ld_sel;
        LD_DATA   = ld_data;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    int stalls;
    int exp_stalls;

    initial begin
        checks = 0;
        errors = 0;
        RESETN = 1'b0;
        idle();
`ifdef ALU_ISSUE_FWD_EN
        exp_stalls = 1;
`else
        exp_stalls = 2;
`endif
        fork
            forever begin
                @(negedge CLK);
                if (model_valid) compare_all();
            end
        join_none

        tick(); tick();
        @(negedge CLK);
        checkOutput("rst_ready", {7'd0, REQ_READY}, 8'h00);
        checkOutput("rst_busy", {7'd0, BUSY}, 8'h00);
        checkOutput("rst_reg_a", REG_A, 8'h00);
        checkOutput("rst_res_valid", {7'd0, RES_VALID}, 8'h00);
        tick();
        RESETN = 1'b1;
        tick();

        // Add with writeback to A, two-cycle latency.
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05); tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03); tick();
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("add_ready", {7'd0, REQ_READY}, 8'h01);
        tick(); idle(); tick();
        @(negedge CLK);
        checkOutput("add_early_valid", {7'd0, RES_VALID}, 8'h00);
        tick();
        @(negedge CLK);
        checkOutput("add_res_valid", {7'd0, RES_VALID}, 8'h01);
        checkOutput("add_res_data", RES_DATA, 8'h08);
        checkOutput("add_reg_a", REG_A, 8'h08);

        // Dependent increments stall on the pending writeback.
        tick();
        applyStimulus(1'b1, 8'h50, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        stalls = 0;
        while (REQ_READY !== 1'b1 && stalls < 10) begin
            stalls++;
            tick();
        end
        checkOutput("raw_stall_cycles", 8'(stalls), 8'(exp_stalls));
        tick(); idle(); tick(); tick();
        @(negedge CLK);
        checkOutput("inc2_res_valid", {7'd0, RES_VALID}, 8'h01);
        checkOutput("inc2_res_data", RES_DATA, 8'h0A);
        checkOutput("inc2_reg_a", REG_A, 8'h0A);

        // Back-to-back compares without writeback run at full rate.
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08); tick();
        applyStimulus(1'b1, 8'h90, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        checkOutput("cmp_ready_1", {7'd0, REQ_READY}, 8'h01);
        applyStimulus(1'b1, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        checkOutput("cmp_ready_2", {7'd0, REQ_READY}, 8'h01);
        applyStimulus(1'b1, 8'hB0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle();
        @(negedge CLK);
        checkOutput("cmp_eq", RES_DATA, 8'h00);
        checkOutput("cmp_eq_valid", {7'd0, RES_VALID}, 8'h01);
        tick();
        @(negedge CLK);
        checkOutput("cmp_gt", RES_DATA, 8'h01);
        checkOutput("cmp_gt_valid", {7'd0, RES_VALID}, 8'h01);
        tick();
        @(negedge CLK);
        checkOutput("cmp_lt", RES_DATA, 8'h00);
        checkOutput("cmp_lt_valid", {7'd0, RES_VALID}, 8'h01);

        // Immediate operand with writeback to B.
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04); tick();
        applyStimulus(1'b1, 8'h0D, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); tick();
        idle(); tick(); tick();
        @(negedge CLK);
        checkOutput("imm_res_data", RES_DATA, 8'h14);
        checkOutput("imm_reg_b", REG_B, 8'h14);
        checkOutput("imm_reg_a", REG_A, 8'h04);

        // Host load beats a writeback to the same register at the same edge.
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle(); tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77); tick();
        idle();
        @(negedge CLK);
        checkOutput("ldwin_reg_a", REG_A, 8'h77);
        checkOutput("ldwin_res_data", RES_DATA, 8'h18);
        checkOutput("ldwin_res_valid", {7'd0, RES_VALID}, 8'h01);

        // Operands are sampled before a load at the accept edge.
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20); tick();
        idle(); tick(); tick();
        @(negedge CLK);
        checkOutput("presample_res", RES_DATA, 8'h8B);
        checkOutput("presample_reg_a", REG_A, 8'h20);

        // Reset right after accept flushes the op.
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick();
        idle();
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        @(negedge CLK);
        checkOutput("flush_ready", {7'd0, REQ_READY}, 8'h01);
        checkOutput("flush_busy", {7'd0, BUSY}, 8'h00);
        checkOutput("flush_reg_a", REG_A, 8'h00);
        checkOutput("flush_reg_b", REG_B, 8'h00);
        tick(); tick();
        @(negedge CLK);
        checkOutput("flush_no_result", {7'd0, RES_VALID}, 8'h00);
        checkOutput("flush_reg_a_late", REG_A, 8'h00);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
